// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 encodings and data-memory controller state type
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the byte/halfword lane of a read word and sign/zero-extends it
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    case (funct3)
      F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   result = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  result = {24'd0, byte_lane};
      F3_LHU:  result = {16'd0, half_lane};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MA-stage data-memory request/ack controller; DMEM_TIMEOUT_EN adds a bus timeout
module dmem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ma_mem_rd,
  input  logic                  i_ma_mem_wr,
  input  logic [ADDR_WIDTH-1:0] i_ma_addr,
  input  logic [31:0]           i_ma_wdata,
  input  logic [2:0]            i_ma_funct3,
  output logic                  o_data_ready,
  output logic [31:0]           o_rdata,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata
);

  dmem_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q;
  logic [2:0]            funct3_q;
  logic                  we_q, mem_req_q;
  logic                  req_any, misaligned, launch, timeout;
  logic                  is_byte, is_half;

  assign req_any    = i_ma_mem_rd | i_ma_mem_wr;
  assign is_byte    = (i_ma_funct3[1:0] == 2'b00);
  assign is_half    = (i_ma_funct3[1:0] == 2'b01);
  assign misaligned = (is_half & i_ma_addr[0]) | (!is_byte & !is_half & (|i_ma_addr[1:0]));
  assign launch     = (state_q == IDLE) & req_any & !misaligned;

  // Lane selection is shared by loads and stores; only the size bits matter.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_ma_wdata;
    case ({1'b0, i_ma_funct3[1:0]})
      F3_SB: begin
        be_d    = 4'b0001 << i_ma_addr[1:0];
        wdata_d = {4{i_ma_wdata[7:0]}};
      end
      F3_SH: begin
        be_d    = i_ma_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{i_ma_wdata[15:0]}};
      end
      F3_SW:   be_d = 4'b1111;
      default: be_d = 4'b1111;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_data_ready = 1'b1;
    o_misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        o_data_ready = !req_any | misaligned;
        o_misaligned = req_any & misaligned;
        if (launch) state_d = BUS;
      end
      BUS: begin
        o_data_ready = 1'b0;
        if (i_mem_ack || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      mem_req_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (launch) begin
          addr_q    <= i_ma_addr;
          be_q      <= be_d;
          wdata_q   <= wdata_d;
          funct3_q  <= i_ma_funct3;
          we_q      <= i_ma_mem_wr & ~i_ma_mem_rd;
          mem_req_q <= 1'b1;
        end
        BUS: begin
          if (i_mem_ack) begin
            rdata_q   <= i_mem_rdata;
            mem_req_q <= 1'b0;
          end else if (timeout) begin
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;

  // Counter holds the number of BUS cycles already elapsed without ack.
  assign timeout = (state_q == BUS) && !i_mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (launch)              cnt_q <= '0;
      else if (state_q == BUS) cnt_q <= cnt_q + 1'b1;
      if (timeout)             bus_err_q <= 1'b1;
      else if (state_q == DONE) bus_err_q <= 1'b0;
    end
  end

  assign o_bus_err = bus_err_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign o_bus_err          = 1'b0;
`endif

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;

  load_align u_load_align (
    .word    (rdata_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (o_rdata)
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic        ack;
  logic [31:0] mrdata;
  logic        o_data_ready, o_misaligned, o_bus_err, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  dmem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ma_mem_rd  (rd),
    .i_ma_mem_wr  (wr),
    .i_ma_addr    (addr),
    .i_ma_wdata   (wdata),
    .i_ma_funct3  (f3),
    .o_data_ready (o_data_ready),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (ack),
    .i_mem_rdata  (mrdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: access size in bytes and arithmetic lane rules.
  function automatic int m_size(input logic [2:0] fn);
    case (fn[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] fn, input logic [31:0] a);
    return (int'(a[1:0]) % m_size(fn)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] fn, input logic [31:0] a);
    int n = m_size(fn);
    int off = (n == 4) ? 0 : int'(a[1:0]);
    int mask = (1 << n) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] fn, input logic [31:0] d);
    int n = m_size(fn);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] w);
    int n = m_size(fn);
    int off = int'(a[1:0]);
    longint v;
    if (n == 4) return w;
    v = longint'(w >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (!fn[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic run_access(input string tag, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] fn, input logic [31:0] word,
                            input int wait_n, input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] erd, input logic emis);
    int low;
    logic ewe;
    ewe = w & ~r;
    rd = r; wr = w; addr = a; wdata = wd; f3 = fn;
    #1;
    chk1({tag, ".mis"}, o_misaligned, emis);
    chk1({tag, ".rdy0"}, o_data_ready, emis);
    if (emis) begin
      step();
      chk1({tag, ".noreq"}, o_mem_req, 1'b0);
      chk1({tag, ".rdy_mis"}, o_data_ready, 1'b1);
      rd = 1'b0; wr = 1'b0;
      return;
    end
    low = 1;
    step();
    chk1({tag, ".req"}, o_mem_req, 1'b1);
    chk({tag, ".addr"}, o_mem_addr, a & 32'hFFFF_FFFC);
    chk({tag, ".be"}, {28'd0, o_mem_be}, {28'd0, ebe});
    chk1({tag, ".we"}, o_mem_we, ewe);
    if (ewe) chk({tag, ".wdata"}, o_mem_wdata, ewd);
    for (int i = 0; i <= wait_n; i++) begin
      if (!o_data_ready && o_mem_req) low++;
      if (i == wait_n) begin
        ack = 1'b1;
        mrdata = word;
      end
      step();
      ack = 1'b0;
      mrdata = $urandom;
    end
    chk1({tag, ".rdy_done"}, o_data_ready, 1'b1);
    chk({tag, ".low_cycles"}, 32'(low), 32'(wait_n + 2));
    chk1({tag, ".req_drop"}, o_mem_req, 1'b0);
    if (!ewe) chk({tag, ".rdata"}, o_rdata, erd);
    rd = 1'b0; wr = 1'b0;
    step();
    chk1({tag, ".rdy_idle"}, o_data_ready, 1'b1);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  fn;
    logic [31:0] word;
    int          wait_n;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        mis;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    logic r, w;
    logic [2:0] fn;
    logic [31:0] a, wd, word;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        3'b010, 32'hDEAD_BEEF, 0, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h103, 32'h0,        3'b000, 32'h80FF_0000, 0, 4'h8, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h103, 32'h0,        3'b100, 32'h80FF_0000, 1, 4'h8, 32'h0,        32'h0000_0080, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h202, 32'h0000_ABCD, 3'b001, 32'h0,        0, 4'hC, 32'hABCD_ABCD, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h101, 32'h0,        3'b010, 32'h0,        0, 4'h0, 32'h0,        32'h0,         1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h102, 32'h0,        3'b001, 32'h8001_1234, 0, 4'hC, 32'h0,        32'hFFFF_8001, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h301, 32'h1234_5677, 3'b000, 32'h0,        2, 4'h2, 32'h7777_7777, 32'h0,        1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h406, 32'h5555_5555, 3'b101, 32'hBEEF_0000, 2, 4'hC, 32'h0,        32'h0000_BEEF, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'h10,  32'hCAFE_F00D, 3'b010, 32'h0,        1, 4'hF, 32'hCAFE_F00D, 32'h0,        1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'h203, 32'h0,        3'b001, 32'h0,        0, 4'h0, 32'h0,        32'h0,         1'b1};

    i_rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; f3 = '0; ack = 1'b0; mrdata = '0;
    step();
    step();
    chk1("rst.req", o_mem_req, 1'b0);
    chk1("rst.we", o_mem_we, 1'b0);
    chk("rst.be", {28'd0, o_mem_be}, 32'd0);
    chk("rst.addr", o_mem_addr, 32'd0);
    chk("rst.wdata", o_mem_wdata, 32'd0);
    chk("rst.rdata", o_rdata, 32'd0);
    chk1("rst.bus_err", o_bus_err, 1'b0);
    chk1("rst.ready", o_data_ready, 1'b1);
    i_rst = 1'b0;
    step();

    foreach (vecs[k])
      run_access($sformatf("vec%0d", k), vecs[k].r, vecs[k].w, vecs[k].a, vecs[k].wd, vecs[k].fn,
                 vecs[k].word, vecs[k].wait_n, vecs[k].be, vecs[k].ewd, vecs[k].erd, vecs[k].mis);

    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(2, 0));
      r = (n != 1);
      w = (n != 0);
      fn = r ? ld_f3[$urandom_range(4, 0)] : 3'($urandom_range(2, 0));
      a = $urandom;
      wd = $urandom;
      word = $urandom;
      run_access($sformatf("rnd%0d", i), r, w, a, wd, fn, word, int'($urandom_range(3, 0)),
                 m_be(fn, a), m_wd(fn, wd), m_ld(fn, a, word), m_mis(fn, a));
    end

    // Request still present in DONE must wait for IDLE before launching.
    rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h100;
    step();
    ack = 1'b1; mrdata = 32'h1122_3344;
    step();
    ack = 1'b0;
    chk("b2b.rdata1", o_rdata, 32'h1122_3344);
    addr = 32'h104;
    step();
    chk1("b2b.idle_noreq", o_mem_req, 1'b0);
    chk1("b2b.idle_rdy", o_data_ready, 1'b0);
    step();
    chk1("b2b.req2", o_mem_req, 1'b1);
    chk("b2b.addr2", o_mem_addr, 32'h104);
    ack = 1'b1; mrdata = 32'h5566_7788;
    step();
    ack = 1'b0; rd = 1'b0;
    chk("b2b.rdata2", o_rdata, 32'h5566_7788);
    step();

    // Slow ack, then reset in the middle of a second access.
    run_access("slow", 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 32'h0BAD_F00D, 4,
               4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);
    rd = 1'b1; f3 = 3'b010; addr = 32'h300;
    step();
    step();
    chk1("midrst.req_before", o_mem_req, 1'b1);
    i_rst = 1'b1; rd = 1'b0;
    step();
    i_rst = 1'b0;
    chk1("midrst.req", o_mem_req, 1'b0);
    chk("midrst.addr", o_mem_addr, 32'd0);
    chk("midrst.be", {28'd0, o_mem_be}, 32'd0);
    chk1("midrst.ready", o_data_ready, 1'b1);
    ack = 1'b1; mrdata = 32'hFFFF_FFFF;
    step();
    ack = 1'b0;
    step();
    chk1("stale.req", o_mem_req, 1'b0);
    chk("stale.rdata", o_rdata, 32'd0);
    chk1("stale.ready", o_data_ready, 1'b1);

    rd = 1'b1; f3 = 3'b010; addr = 32'h500;
    step();
`ifdef DMEM_TIMEOUT_EN
    n = 0;
    while (!o_data_ready && n < 20) begin
      n++;
      step();
    end
    chk("tmo.bus_cycles", 32'(n), 32'd4);
    chk1("tmo.bus_err", o_bus_err, 1'b1);
    chk("tmo.rdata", o_rdata, 32'd0);
    chk1("tmo.req", o_mem_req, 1'b0);
    rd = 1'b0;
    step();
    ack = 1'b1; mrdata = 32'h1234_5678;
    step();
    ack = 1'b0;
    chk1("tmo.late_err", o_bus_err, 1'b0);
    chk1("tmo.late_req", o_mem_req, 1'b0);
    chk1("tmo.late_rdy", o_data_ready, 1'b1);
`else
    n = 0;
    for (int i = 0; i < 120; i++) begin
      if (o_mem_req && !o_data_ready) n++;
      step();
    end
    chk("hold.cycles", 32'(n), 32'd120);
    chk1("hold.no_err", o_bus_err, 1'b0);
    i_rst = 1'b1; rd = 1'b0;
    step();
    i_rst = 1'b0;
    chk1("hold.rst_req", o_mem_req, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access controller for the memory-access (MA) stage.
- Takes load/store requests from MA and drives a request/acknowledge bus toward data memory, which may take many cycles to answer.
- Generates the data-memory ready flag that the hazard control unit uses to stall the front of the pipeline.
- Returns load data aligned and sign/zero-extended.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- TIMEOUT_CYCLES, 255: cycles in BUS before a bus error is declared. Used only with DMEM_TIMEOUT_EN.

Ports:
- i_clk, input, 1: clock. Everything is sampled on the rising edge.
- i_rst, input, 1: synchronous reset, active-high.
- i_ma_mem_rd, input, 1: MA stage requests a load.
- i_ma_mem_wr, input, 1: MA stage requests a store.
- i_ma_addr, input, ADDR_WIDTH: byte address.
- i_ma_wdata, input, 32: store data, right-aligned.
- i_ma_funct3, input, 3: size and sign. Encodings: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- o_data_ready, output, 1: data-memory ready, sent to hazard control. Low means stall.
- o_rdata, output, 32: extended load result. Valid while o_data_ready=1 in DONE.
- o_misaligned, output, 1: current request is misaligned and is not issued.
- o_bus_err, output, 1: bus timeout error. Only with DMEM_TIMEOUT_EN.
- o_mem_req, output, 1: memory request, registered.
- o_mem_we, output, 1: write enable.
- o_mem_addr, output, ADDR_WIDTH: word-aligned address (low 2 bits = 0).
- o_mem_be, output, 4: byte enables.
- o_mem_wdata, output, 32: lane-replicated store data.
- i_mem_ack, input, 1: memory completion, one-cycle pulse.
- i_mem_rdata, input, 32: read word. Valid when i_mem_ack=1.

Behaviour:
- Reset values: state=IDLE. o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_rdata, o_bus_err all 0.
- Reset mid-transaction: state returns to IDLE and o_mem_req drops at that edge. An i_mem_ack arriving later is ignored.
- States and transitions:
  - IDLE: o_data_ready = !(rd|wr) | misaligned (combinational). On a valid aligned request, register address, byte enables, write data, we and funct3 → BUS.
  - BUS: o_mem_req=1 and o_data_ready=0. Stay until i_mem_ack=1; then capture i_mem_rdata → DONE.
  - DONE: o_data_ready=1 and o_rdata valid for exactly one cycle → IDLE. A request present in DONE is not launched; it is treated as a new request in IDLE on the next cycle.
- Minimum latency: request in cycle 0, o_mem_req high in cycle 1, ack in cycle 1, DONE in cycle 2. o_data_ready is low in cycles 0–1.
- MA holds its request stable while o_data_ready=0. The controller uses only its registered copy once it leaves IDLE.
- rd and wr asserted together: load takes priority and wr is ignored.
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]≠0, counts as misaligned.
  - The request stays in IDLE, o_mem_req is not raised, o_misaligned=1 combinationally and o_data_ready=1.
- Store byte enables and data:
  - SB: be = 1<<addr[1:0]; data byte replicated ×4.
  - SH: be = 0011 if addr[1]=0, else 1100; halfword replicated ×2.
  - SW: be = 1111.
- Loads: select the byte or halfword lane from the captured word using the registered addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- o_mem_be on loads: same lane rule as stores.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - An 8+ bit counter clears on BUS entry and increments each BUS cycle.
  - When the count reaches TIMEOUT_CYCLES without ack: drop o_mem_req and go to DONE with o_rdata=0 and o_bus_err=1 for that DONE cycle.
  - A late ack after the timeout is ignored.
- DMEM_TIMEOUT_EN undefined: o_bus_err is tied 0 and BUS waits indefinitely.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 load/store localparams.
  - dmem_state_t enum: IDLE, BUS, DONE.
- One sub-module, load_align: combinational. Inputs are the word, addr[1:0] and funct3; output is the extended 32-bit result.
- Byte-enable and replication logic stays inline.

Test Plan:
- LW at 0x100, ack on first BUS cycle, rdata=0xDEADBEEF → o_mem_req high 1 cycle, o_data_ready low 2 cycles, o_rdata=0xDEADBEEF in DONE.
- LB at 0x103, memory word 0x80FF_0000 → o_mem_be=1000, o_rdata=0xFFFFFF80. LBU same → 0x00000080.
- SH at 0x202, wdata=0x0000_ABCD → o_mem_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1.
- LW at 0x101 → o_misaligned=1, o_mem_req never rises, o_data_ready stays 1.
- Ack delayed 5 cycles, then i_rst pulsed in BUS on a second access → first access has ready low for 6 cycles. After reset all outputs are 0 and a stale ack has no effect.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack → o_bus_err=1 and o_rdata=0 in DONE. Without the macro, o_mem_req is held for 100+ cycles.
